// File: rtl/intc_pkg.sv
// intc_pkg: shared types for the interrupt controller.
// Holds NUM_IRQ, the FSM state enum and the one-hot priority select.
package intc_pkg;

    localparam int NUM_IRQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SERVICE
    } state_t;

    // Lowest set bit of req as a one-hot vector; zero in, zero out.
    function automatic logic [NUM_IRQ-1:0] prio_sel(
        input logic [NUM_IRQ-1:0] req
    );
        logic [NUM_IRQ-1:0] g;
        g = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/intc_if.sv
// intc_if: CPU/peripheral side signals of the interrupt controller.
// master: irq, fin_interrup (+ mask_we, mask_data with INTC_MASK_EN)
// drive; slave: interrup, p_entrada, pending drive.
interface intc_if;
    import intc_pkg::*;

    logic [NUM_IRQ-1:0] irq;
    logic               fin_interrup;
`ifdef INTC_MASK_EN
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_data;
`endif
    logic               interrup;
    logic [NUM_IRQ-1:0] p_entrada;
    logic [NUM_IRQ-1:0] pending;

`ifdef INTC_MASK_EN
    modport master (
        output irq, fin_interrup, mask_we, mask_data,
        input  interrup, p_entrada, pending
    );
    modport slave (
        input  irq, fin_interrup, mask_we, mask_data,
        output interrup, p_entrada, pending
    );
`else
    modport master (
        output irq, fin_interrup,
        input  interrup, p_entrada, pending
    );
    modport slave (
        input  irq, fin_interrup,
        output interrup, p_entrada, pending
    );
`endif

endinterface

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational fixed-priority encoder.
// req -> gnt, lowest index wins, one-hot out, zero when req is zero.
module intc_prio_enc
    import intc_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [NUM_IRQ-1:0] gnt
);

    assign gnt = prio_sel(req);

endmodule

// File: rtl/intc.sv
// intc: 4-line edge-triggered interrupt controller, one service at a time.
// Ports: clk, reset (sync, active high), bus (intc_if.slave).
// INTC_MASK_EN adds a writable mask register; otherwise mask is 0.
module intc
    import intc_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    intc_if.slave  bus
);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] grant_q, grant_d;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] sel;

    assign rise = bus.irq & ~irq_q;
    assign elig = pend_q & ~mask;

    intc_prio_enc u_prio (
        .req (elig),
        .gnt (sel)
    );

`ifdef INTC_MASK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (bus.mask_we) begin
            mask <= bus.mask_data;
        end
    end
`else
    assign mask = '0;
`endif

    // A new rise overrides the grant clear on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= bus.irq;
            pend_q <= (pend_q & ~clr) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        clr           = '0;
        bus.interrup  = 1'b0;
        bus.p_entrada = '0;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = ACTIVE;
                    grant_d = sel;
                end
            end
            ACTIVE: begin
                bus.interrup  = 1'b1;
                bus.p_entrada = grant_q;
                clr           = grant_q;
                state_d       = SERVICE;
            end
            SERVICE: begin
                bus.p_entrada = grant_q;
                if (bus.fin_interrup) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pending = pend_q;

endmodule

// File: tb/tb_intc.sv
// tb_intc: scoreboard bench for intc; expected grants are queued by the
// stimulus and popped by a monitor whenever interrup is seen.
module tb_intc;
    import intc_pkg::*;

    logic clk;
    logic reset;
    int   errs;
    int   checks;

    logic [3:0] exp_q[$];

    intc_if bus ();

    intc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic wait_grant(input string nm);
        int n;
        n = 0;
        while (bus.interrup !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.interrup !== 1'b1) begin
            errs++;
            $display("FAIL %s: got no grant expected grant in 20 cycles",
                     nm);
        end
    endtask

    // Called in the ACTIVE cycle; leaves the FSM back in IDLE.
    task automatic do_service();
        tick();
        bus.fin_interrup = 1'b1;
        tick();
        bus.fin_interrup = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        logic [3:0] e;
        if (bus.interrup === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_grant: got %b expected none",
                         bus.p_entrada);
            end else begin
                e = exp_q.pop_front();
                chk("grant", bus.p_entrada, e);
            end
        end
    end

    initial begin
        int n;
        errs             = 0;
        checks           = 0;
        reset            = 1'b1;
        bus.irq          = '0;
        bus.fin_interrup = 1'b0;
`ifdef INTC_MASK_EN
        bus.mask_we      = 1'b0;
        bus.mask_data    = '0;
`endif
        tick();
        tick();
        chk("rst_interrup", {3'b0, bus.interrup}, 4'b0000);
        chk("rst_p_entrada", bus.p_entrada, 4'b0000);
        chk("rst_pending", bus.pending, 4'b0000);
        reset = 1'b0;
        tick();

        // Single line, latency and hold until fin_interrup.
        bus.irq = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        chk("lat_pending", bus.pending, 4'b0100);
        chk("lat_no_int_yet", {3'b0, bus.interrup}, 4'b0000);
        tick();
        chk("lat_int", {3'b0, bus.interrup}, 4'b0001);
        chk("lat_p_entrada", bus.p_entrada, 4'b0100);
        bus.irq = 4'b0000;
        tick();
        chk("svc_int_low", {3'b0, bus.interrup}, 4'b0000);
        chk("svc_p_entrada", bus.p_entrada, 4'b0100);
        chk("svc_pend_clr", bus.pending, 4'b0000);
        repeat (3) tick();
        chk("svc_hold", bus.p_entrada, 4'b0100);
        bus.fin_interrup = 1'b1;
        tick();
        bus.fin_interrup = 1'b0;
        chk("idle_p_entrada", bus.p_entrada, 4'b0000);
        tick();

        // Priority: lines 1 and 3 together.
        bus.irq = 4'b1010;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        tick();
        bus.irq = 4'b0000;
        wait_grant("prio_first");
        do_service();
        chk("prio_idle_gap", {3'b0, bus.interrup}, 4'b0000);
        chk("prio_pend_left", bus.pending, 4'b1000);
        tick();
        chk("prio_second", {3'b0, bus.interrup}, 4'b0001);
        do_service();
        chk("prio_pend_done", bus.pending, 4'b0000);

        // Re-trigger of line 0 on the grant-clear edge.
        bus.irq = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        bus.irq = 4'b0000;
        tick();
        chk("retrig_active", {3'b0, bus.interrup}, 4'b0001);
        bus.irq = 4'b0001;
        tick();
        chk("retrig_set_wins", bus.pending, 4'b0001);
        exp_q.push_back(4'b0001);
        bus.fin_interrup = 1'b1;
        tick();
        bus.fin_interrup = 1'b0;
        bus.irq = 4'b0000;
        tick();
        chk("retrig_regrant", {3'b0, bus.interrup}, 4'b0001);
        do_service();
        chk("retrig_pend_done", bus.pending, 4'b0000);

        // Reset in SERVICE with line 3 pending.
        bus.irq = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        bus.irq = 4'b0000;
        wait_grant("rst_mid_grant");
        tick();
        bus.irq = 4'b1000;
        tick();
        bus.irq = 4'b0000;
        chk("rst_mid_pending", bus.pending, 4'b1000);
        reset = 1'b1;
        tick();
        chk("rst_mid_int", {3'b0, bus.interrup}, 4'b0000);
        chk("rst_mid_p_entrada", bus.p_entrada, 4'b0000);
        chk("rst_mid_pend", bus.pending, 4'b0000);
        reset = 1'b0;
        repeat (10) tick();
        chk("rst_mid_no_grant", bus.p_entrada, 4'b0000);

        // Line high across reset release counts as a rise.
        bus.irq = 4'b0010;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(4'b0010);
        tick();
        chk("rel_rise_pend", bus.pending, 4'b0010);
        wait_grant("rel_rise_grant");
        do_service();
        repeat (5) tick();
        bus.irq = 4'b0000;
        tick();

        // Held level on line 2 for 20 cycles: a single grant.
        bus.irq = 4'b0100;
        exp_q.push_back(4'b0100);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.interrup === 1'b1) n++;
            bus.fin_interrup = (bus.p_entrada != 4'b0000) &&
                               (bus.interrup !== 1'b1);
        end
        bus.fin_interrup = 1'b0;
        bus.irq = 4'b0000;
        chk("held_one_grant", n[3:0], 4'd1);
        tick();

`ifdef INTC_MASK_EN
        // Masked line latches pending, granted once unmasked.
        bus.mask_we   = 1'b1;
        bus.mask_data = 4'b0001;
        tick();
        bus.mask_we = 1'b0;
        bus.irq     = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        repeat (3) tick();
        chk("mask_pending", bus.pending, 4'b0001);
        chk("mask_no_int", {3'b0, bus.interrup}, 4'b0000);
        bus.mask_we   = 1'b1;
        bus.mask_data = 4'b0000;
        tick();
        bus.mask_we = 1'b0;
        chk("mask_write_edge", {3'b0, bus.interrup}, 4'b0000);
        exp_q.push_back(4'b0001);
        tick();
        chk("unmask_grant", {3'b0, bus.interrup}, 4'b0001);
        do_service();
`endif

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL missing_grants: got %0d left expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
